// File: rtl/pwm_signal_generator.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pwm_signal_generator: 4-channel double-buffered PWM generator on the        |
// | analyzer command bus. Burst support enabled by PWM_SIG_GEN_BURST_EN. Rev 1.0|
// +-----------------------------------------------------------------------------+
module pwm_signal_generator #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        cmd_opcode,
    input  logic [15:0]       cmd_addr,
    input  logic [31:0]       cmd_data,
    input  logic              cmd_valid,
    output logic [CH_NUM-1:0] sig_out,
    output logic [31:0]       tx_data,
    output logic              tx_en,
    input  logic              tx_done
);
    localparam logic [7:0] OP_PERIOD = 8'h20;
    localparam logic [7:0] OP_HIGH   = 8'h21;
    localparam logic [7:0] OP_BURST  = 8'h22;
    localparam logic [7:0] OP_RUN    = 8'h23;
    localparam logic [7:0] OP_READ   = 8'h24;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [CNT_W-1:0]  per_sh_q   [CH_NUM], per_sh_d   [CH_NUM];
    logic [CNT_W-1:0]  high_sh_q  [CH_NUM], high_sh_d  [CH_NUM];
    logic [CNT_W-1:0]  burst_sh_q [CH_NUM], burst_sh_d [CH_NUM];
    logic [CNT_W-1:0]  act_per_q  [CH_NUM], act_per_d  [CH_NUM];
    logic [CNT_W-1:0]  act_high_q [CH_NUM], act_high_d [CH_NUM];
    logic [CNT_W-1:0]  cnt_q      [CH_NUM], cnt_d      [CH_NUM];
    logic [CNT_W-1:0]  rem_q      [CH_NUM], rem_d      [CH_NUM];
    logic [1:0]        state_q    [CH_NUM], state_d    [CH_NUM];
    logic [CH_NUM-1:0] done_q, done_d;
    logic [CH_NUM-1:0] sig_out_q, sig_out_d;
    logic [31:0]       tx_data_q, tx_data_d;
    logic              tx_en_q, tx_en_d;

    logic [1:0]        w_ch;
    logic              w_ch_ok;
    logic              w_run_cmd;
    logic              w_wrap;
    logic [CNT_W-1:0]  w_load_per;
    logic [CNT_W-1:0]  w_load_high;
    logic [CH_NUM-1:0] w_run;

    always_comb begin
        w_ch        = cmd_addr[1:0];
        w_ch_ok     = cmd_addr < 16'(CH_NUM);
        w_run_cmd   = cmd_valid && (cmd_opcode == OP_RUN);
        per_sh_d    = per_sh_q;
        high_sh_d   = high_sh_q;
        burst_sh_d  = burst_sh_q;
        act_per_d   = act_per_q;
        act_high_d  = act_high_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        state_d     = state_q;
        done_d      = done_q;
        sig_out_d   = '0;
        w_run       = '0;
        w_wrap      = 1'b0;
        w_load_per  = '0;
        w_load_high = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            w_run[c] = (state_q[c] == S_RUN);
            if (cmd_valid && w_ch_ok && (w_ch == 2'(c))) begin
                case (cmd_opcode)
                    OP_PERIOD: per_sh_d[c]   = CNT_W'(cmd_data);
                    OP_HIGH:   high_sh_d[c]  = CNT_W'(cmd_data);
`ifdef PWM_SIG_GEN_BURST_EN
                    OP_BURST:  burst_sh_d[c] = CNT_W'(cmd_data);
`endif
                    default: ;
                endcase
            end
            // Loads always sample the pre-edge shadows, so the running period finishes untouched.
            w_load_per  = (per_sh_q[c] < CNT_W'(2)) ? CNT_W'(2) : per_sh_q[c];
            w_load_high = (high_sh_q[c] > w_load_per) ? w_load_per : high_sh_q[c];
            w_wrap      = (cnt_q[c] == act_per_q[c] - CNT_W'(1));
            if (w_run_cmd && !cmd_data[c]) begin
                state_d[c] = S_IDLE;
            end else if (w_run_cmd && ((state_q[c] == S_IDLE) || (state_q[c] == S_DONE))) begin
                state_d[c]    = S_RUN;
                done_d[c]     = 1'b0;
                cnt_d[c]      = '0;
                act_per_d[c]  = w_load_per;
                act_high_d[c] = w_load_high;
                rem_d[c]      = burst_sh_q[c];
            end else if (state_q[c] == S_RUN) begin
                if (w_wrap) begin
                    cnt_d[c]      = '0;
                    act_per_d[c]  = w_load_per;
                    act_high_d[c] = w_load_high;
`ifdef PWM_SIG_GEN_BURST_EN
                    if (rem_q[c] != '0) begin
                        rem_d[c] = rem_q[c] - CNT_W'(1);
                        if (rem_q[c] == CNT_W'(1)) begin
                            state_d[c] = S_DONE;
                            done_d[c]  = 1'b1;
                        end
                    end
`endif
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end
            sig_out_d[c] = (state_d[c] == S_RUN) && (cnt_d[c] < act_high_d[c]);
        end
    end

    always_comb begin
        tx_data_d = tx_data_q;
        tx_en_d   = tx_en_q;
        if (cmd_valid && (cmd_opcode == OP_READ)) begin
            if (cmd_data[1:0] == 2'd3) begin
                tx_data_d = 32'({done_q, w_run});
                tx_en_d   = 1'b1;
            end else if (w_ch_ok) begin
                tx_en_d = 1'b1;
                case (cmd_data[1:0])
                    2'd0:    tx_data_d = 32'(per_sh_q[w_ch]);
                    2'd1:    tx_data_d = 32'(high_sh_q[w_ch]);
                    default: tx_data_d = 32'(rem_q[w_ch]);
                endcase
            end
        end else if (!cmd_valid && tx_done) begin
            tx_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH_NUM; c++) begin
                per_sh_q[c]   <= '0;
                high_sh_q[c]  <= '0;
                burst_sh_q[c] <= '0;
                act_per_q[c]  <= '0;
                act_high_q[c] <= '0;
                cnt_q[c]      <= '0;
                rem_q[c]      <= '0;
                state_q[c]    <= S_IDLE;
            end
            done_q    <= '0;
            sig_out_q <= '0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            per_sh_q   <= per_sh_d;
            high_sh_q  <= high_sh_d;
            burst_sh_q <= burst_sh_d;
            act_per_q  <= act_per_d;
            act_high_q <= act_high_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            state_q    <= state_d;
            done_q     <= done_d;
            sig_out_q  <= sig_out_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
        end
    end

    assign sig_out = sig_out_q;
    assign tx_data = tx_data_q;
    assign tx_en   = tx_en_q;
endmodule
`default_nettype wire

// File: tb/tb_pwm_signal_generator.sv
`default_nettype none
// Bench for pwm_signal_generator: handshake table, directed waveform sequences and
// randomized commands against a queue-based waveform model.
module tb_pwm_signal_generator;
`ifdef PWM_SIG_GEN_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cmd_opcode = '0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        cmd_valid = 1'b0;
    logic [3:0]  sig_out;
    logic [31:0] tx_data;
    logic        tx_en;
    logic        tx_done = 1'b0;

    pwm_signal_generator #(.CH_NUM(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .sig_out(sig_out),
        .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: each running channel holds the remaining output levels of its current period.
    int unsigned m_per_sh[4], m_high_sh[4], m_burst_sh[4], m_rem[4];
    bit          m_run[4], m_done[4];
    bit          m_wave[4][$];
    logic [3:0]  m_sig;
    logic        m_txen;
    logic [31:0] m_txdata;

    function automatic void model_init();
        for (int c = 0; c < 4; c++) begin
            m_per_sh[c] = 0; m_high_sh[c] = 0; m_burst_sh[c] = 0; m_rem[c] = 0;
            m_run[c] = 1'b0; m_done[c] = 1'b0; m_wave[c].delete();
        end
        m_sig = '0; m_txen = 1'b0; m_txdata = '0;
    endfunction

    function automatic void load(int c);
        int unsigned p;
        p = (m_per_sh[c] < 2) ? 2 : m_per_sh[c];
        m_wave[c].delete();
        for (int unsigned k = 0; k < p; k++) m_wave[c].push_back(k < m_high_sh[c]);
    endfunction

    function automatic void model_step(logic [7:0] op, logic [15:0] ad, logic [31:0] dt, logic vl, logic td);
        logic [3:0] rb, db;
        bit start, stop;
        for (int c = 0; c < 4; c++) begin rb[c] = m_run[c]; db[c] = m_done[c]; end
        if (vl && op == 8'h24) begin
            if (dt[1:0] == 2'd3) begin
                m_txdata = {24'd0, db, rb}; m_txen = 1'b1;
            end else if (ad < 16'd4) begin
                m_txen = 1'b1;
                case (dt[1:0])
                    2'd0:    m_txdata = m_per_sh[ad[1:0]];
                    2'd1:    m_txdata = m_high_sh[ad[1:0]];
                    default: m_txdata = m_rem[ad[1:0]];
                endcase
            end
        end else if (!vl && td) begin
            m_txen = 1'b0;
        end
        for (int c = 0; c < 4; c++) begin
            stop  = vl && (op == 8'h23) && !dt[c];
            start = vl && (op == 8'h23) && dt[c];
            m_sig[c] = 1'b0;
            if (stop) begin
                m_run[c] = 1'b0; m_wave[c].delete();
            end else if (start && !m_run[c]) begin
                m_run[c] = 1'b1; m_done[c] = 1'b0;
                m_rem[c] = BURST ? m_burst_sh[c] : 0;
                load(c);
                m_sig[c] = m_wave[c].pop_front();
            end else if (m_run[c]) begin
                if (m_wave[c].size() == 0) begin
                    if (m_rem[c] != 0) begin
                        m_rem[c]--;
                        if (m_rem[c] == 0) begin m_run[c] = 1'b0; m_done[c] = 1'b1; end
                    end
                    if (m_run[c]) load(c);
                end
                if (m_run[c]) m_sig[c] = m_wave[c].pop_front();
            end
        end
        if (vl && ad < 16'd4) begin
            case (op)
                8'h20: m_per_sh[ad[1:0]] = dt;
                8'h21: m_high_sh[ad[1:0]] = dt;
                8'h22: if (BURST) m_burst_sh[ad[1:0]] = dt;
                default: ;
            endcase
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [7:0] op, input logic [15:0] ad, input logic [31:0] dt,
                       input logic vl, input logic td);
        cmd_opcode = op; cmd_addr = ad; cmd_data = dt; cmd_valid = vl; tx_done = td;
        @(posedge clk);
        model_step(op, ad, dt, vl, td);
        #1;
        chk("model sig_out", {28'd0, sig_out}, {28'd0, m_sig});
        chk("model tx_en", {31'd0, tx_en}, {31'd0, m_txen});
        chk("model tx_data", tx_data, m_txdata);
    endtask

    task automatic cmd(input logic [7:0] op, input logic [15:0] ad, input logic [31:0] dt);
        cyc(op, ad, dt, 1'b1, 1'b0);
    endtask

    task automatic idle(input logic td);
        cyc(8'h00, 16'd0, 32'd0, 1'b0, td);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; tx_done = 1'b0;
        rst_n = 1'b0;
        #1;
        model_init();
        chk("reset sig_out", {28'd0, sig_out}, 32'd0);
        chk("reset tx_en", {31'd0, tx_en}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [15:0] ad;
        logic [31:0] dt;
        logic        vl;
        logic        td;
        logic        en;
        logic [31:0] data;
    } vec_t;
    vec_t tbl[13];

    logic [7:0]  r_op;
    logic [31:0] r_dt;
    logic        exp_bit;

    initial begin
        tbl[0]  = '{8'h20, 16'd3, 32'd1000,   1'b1, 1'b0, 1'b0, 32'd0};
        tbl[1]  = '{8'h24, 16'd3, 32'd0,      1'b1, 1'b0, 1'b1, 32'd1000};
        tbl[2]  = '{8'h00, 16'd0, 32'd0,      1'b0, 1'b0, 1'b1, 32'd1000};
        tbl[3]  = '{8'h21, 16'd3, 32'd500,    1'b1, 1'b1, 1'b1, 32'd1000};
        tbl[4]  = '{8'h24, 16'd3, 32'd1,      1'b1, 1'b1, 1'b1, 32'd500};
        tbl[5]  = '{8'h00, 16'd0, 32'd0,      1'b0, 1'b1, 1'b0, 32'd500};
        tbl[6]  = '{8'h24, 16'd7, 32'd0,      1'b1, 1'b0, 1'b0, 32'd500};
        tbl[7]  = '{8'h24, 16'd7, 32'd3,      1'b1, 1'b0, 1'b1, 32'd0};
        tbl[8]  = '{8'h00, 16'd0, 32'd0,      1'b0, 1'b1, 1'b0, 32'd0};
        tbl[9]  = '{8'h10, 16'd0, 32'hFFFF,   1'b1, 1'b0, 1'b0, 32'd0};
        tbl[10] = '{8'h24, 16'd3, 32'd0,      1'b1, 1'b0, 1'b1, 32'd1000};
        tbl[11] = '{8'h24, 16'd0, 32'd0,      1'b1, 1'b0, 1'b1, 32'd0};
        tbl[12] = '{8'h24, 16'd3, 32'd2,      1'b1, 1'b1, 1'b1, 32'd0};

        #15;
        chk("reset sig_out", {28'd0, sig_out}, 32'd0);
        chk("reset tx_en", {31'd0, tx_en}, 32'd0);
        chk("reset tx_data", tx_data, 32'd0);
        model_init();
        #2 rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].op, tbl[i].ad, tbl[i].dt, tbl[i].vl, tbl[i].td);
            chk($sformatf("tbl[%0d] tx_en", i), {31'd0, tx_en}, {31'd0, tbl[i].en});
            chk($sformatf("tbl[%0d] tx_data", i), tx_data, tbl[i].data);
        end
        idle(1'b1);

        // Continuous 3 high / 7 low on channel 0.
        cmd(8'h20, 16'd0, 32'd10);
        cmd(8'h21, 16'd0, 32'd3);
        cmd(8'h23, 16'd0, 32'h1);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) idle(1'b0);
            chk($sformatf("cont ch0 i=%0d", i), {31'd0, sig_out[0]}, {31'd0, (i % 10) < 3});
        end
        cmd(8'h24, 16'd0, 32'd3);
        chk("cont status", tx_data, 32'h1);
        idle(1'b1);

        // High time rewritten mid-period on channel 1.
        cmd(8'h20, 16'd1, 32'd8);
        cmd(8'h21, 16'd1, 32'd4);
        cmd(8'h23, 16'd0, 32'h2);
        chk("ch0 stopped", {31'd0, sig_out[0]}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 3) cmd(8'h21, 16'd1, 32'd6);
            else if (i > 0) idle(1'b0);
            exp_bit = (i < 8) ? (i < 4) : ((i - 8) < 6);
            chk($sformatf("glitchfree ch1 i=%0d", i), {31'd0, sig_out[1]}, {31'd0, exp_bit});
        end

        // Burst of three periods on channel 2.
        cmd(8'h20, 16'd2, 32'd5);
        cmd(8'h21, 16'd2, 32'd2);
        cmd(8'h22, 16'd2, 32'd3);
        cmd(8'h23, 16'd0, 32'h4);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) idle(1'b0);
            exp_bit = BURST ? ((i < 15) && ((i % 5) < 2)) : ((i % 5) < 2);
            chk($sformatf("burst ch2 i=%0d", i), {31'd0, sig_out[2]}, {31'd0, exp_bit});
        end
        cmd(8'h24, 16'd0, 32'd3);
        chk("burst status", tx_data, BURST ? 32'h40 : 32'h04);
        cmd(8'h24, 16'd2, 32'd2);
        chk("burst remaining", tx_data, 32'd0);
        cmd(8'h23, 16'd0, 32'h0);

        // Period clamp, constant low, constant high, stop mid-high.
        cmd(8'h20, 16'd0, 32'd1);
        cmd(8'h21, 16'd0, 32'd1);
        cmd(8'h23, 16'd0, 32'h1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) idle(1'b0);
            chk($sformatf("clamp ch0 i=%0d", i), {31'd0, sig_out[0]}, {31'd0, (i % 2) == 0});
        end
        cmd(8'h23, 16'd0, 32'h0);
        cmd(8'h21, 16'd0, 32'd0);
        cmd(8'h23, 16'd0, 32'h1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) idle(1'b0);
            chk("high0 ch0", {31'd0, sig_out[0]}, 32'd0);
        end
        cmd(8'h23, 16'd0, 32'h0);
        cmd(8'h20, 16'd0, 32'd10);
        cmd(8'h21, 16'd0, 32'd20);
        cmd(8'h23, 16'd0, 32'h1);
        for (int i = 0; i < 25; i++) begin
            if (i > 0) idle(1'b0);
            chk("highmax ch0", {31'd0, sig_out[0]}, 32'd1);
        end
        cmd(8'h23, 16'd0, 32'h0);
        cmd(8'h21, 16'd0, 32'd3);
        cmd(8'h23, 16'd0, 32'h1);
        idle(1'b0);
        chk("pre-stop high", {31'd0, sig_out[0]}, 32'd1);
        cmd(8'h23, 16'd0, 32'h0);
        chk("stop mid-high", {31'd0, sig_out[0]}, 32'd0);

        // Asynchronous reset while every channel runs.
        for (int c = 0; c < 4; c++) begin
            cmd(8'h20, 16'(c), 32'd6);
            cmd(8'h21, 16'(c), 32'd3);
        end
        cmd(8'h23, 16'd0, 32'hF);
        idle(1'b0);
        cmd(8'h24, 16'd0, 32'd0);
        chk("pre-reset sig_out", {28'd0, sig_out}, 32'hF);
        do_reset();
        cmd(8'h24, 16'd0, 32'd3);
        chk("post-reset status", tx_data, 32'd0);
        chk("post-reset tx_en", {31'd0, tx_en}, 32'd1);

        // Randomized commands against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 7))
                0: begin r_op = 8'h20; r_dt = $urandom_range(0, 12); end
                1: begin r_op = 8'h21; r_dt = $urandom_range(0, 14); end
                2: begin r_op = 8'h22; r_dt = $urandom_range(0, 4); end
                3: begin r_op = 8'h23; r_dt = ($urandom_range(0, 9) < 7) ? 32'hF : 32'($urandom_range(0, 15)); end
                4: begin r_op = 8'h24; r_dt = $urandom_range(0, 3); end
                5: begin r_op = 8'h10; r_dt = $urandom; end
                6: begin r_op = 8'h11; r_dt = $urandom; end
                default: begin r_op = 8'($urandom); r_dt = $urandom_range(0, 15); end
            endcase
            cyc(r_op, 16'($urandom_range(0, 5)), r_dt, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
